// File: rtl/mem_access_pkg.sv
// Shared constants and types for the data-memory access unit.
// Size encodings, FSM state type and data width.
package mem_access_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Little-endian; off_i is the byte offset inside the word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [1:0]        off_i,
    input  logic [15:0]       wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word_i[{off_i, 3'b000} +: 8];
        half_v  = word_i[{off_i[1], 4'b0000} +: 16];
        rdata_o = word_i;
        merge_o = word_i;
        unique case (size_i)
            SZ_BYTE: begin
                rdata_o = {{24{sign_i & byte_v[7]}}, byte_v};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                rdata_o = {{16{sign_i & half_v[15]}}, half_v};
                merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: begin
                rdata_o = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: load/store with sub-word RMW and extension.
// MEM_ACCESS_ALIGN_FAULT_EN: fault misaligned/reserved requests.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [31:0]       mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            size_q, size_d;
    logic [DEPTH_LOG2+1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     old_q, old_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [1:0]        in_size;
    logic [1:0]        in_off;
    logic              in_fault;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_rdata;
    logic [DATA_W-1:0] lane_merge;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];

`ifdef MEM_ACCESS_ALIGN_FAULT_EN
    logic fault_q, fault_d;

    always_comb begin
        in_size  = req_size;
        in_off   = req_addr[1:0];
        in_fault = (req_size == SZ_RSVD)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        fault_d = fault_q;
        if (state_q == ST_IDLE && req_valid) begin
            fault_d = in_fault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign resp_fault = resp_valid & fault_q;
`else
    // Without faulting, misaligned requests are aligned down instead.
    always_comb begin
        in_size = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
        in_off  = req_addr[1:0];
        if (in_size == SZ_HALF) begin
            in_off[0] = 1'b0;
        end
        if (in_size == SZ_WORD) begin
            in_off = 2'b00;
        end
        in_fault = 1'b0;
    end

    assign resp_fault = 1'b0;
`endif

    assign lane_word = (state_q == ST_WRITE) ? old_q : mem_RD;

    mem_lane_align u_align (
        .word_i  (lane_word),
        .size_i  (size_q),
        .sign_i  (sgn_q),
        .off_i   (addr_q[1:0]),
        .wdata_i (wdata_q[15:0]),
        .rdata_o (lane_rdata),
        .merge_o (lane_merge)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    sgn_d   = req_signed;
                    size_d  = in_size;
                    addr_d  = {req_addr[DEPTH_LOG2+1:2], in_off};
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    state_d = in_fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = lane_rdata;
                    state_d = ST_RESP;
                end else if (size_q == SZ_WORD) begin
                    state_d = ST_RESP;
                end else begin
                    old_d   = mem_RD;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        req_ready  = rst && (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = (resp_valid && !we_q) ? rdata_q : '0;
        mem_A      = '0;
        mem_A[DEPTH_LOG2-1:0] = addr_q[DEPTH_LOG2+1:2];
        mem_WE = (state_q == ST_ACCESS && we_q && size_q == SZ_WORD)
              || (state_q == ST_WRITE);
        mem_WD = '0;
        if (state_q == ST_WRITE) begin
            mem_WD = lane_merge;
        end else if (mem_WE) begin
            mem_WD = wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
// Covers both builds of MEM_ACCESS_ALIGN_FAULT_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.DATA_W(32), .DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[9:0]];
    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        flt;
        int          lat;
        int          wec;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

`ifdef MEM_ACCESS_ALIGN_FAULT_EN
    localparam logic [31:0] M28_END = 32'hBEEFF080;
`else
    localparam logic [31:0] M28_END = 32'hCAFEF00D;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output int lat, output logic [31:0] rd,
                       output logic flt, output int wec,
                       output logic [31:0] wd, output logic [31:0] wa);
        int n;
        lat = 0; wec = 0; rd = '0; flt = 1'b0; wd = '0; wa = '0;
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept timeout addr=%h", addr);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (mem_WE) begin
                wec++; wd = mem_WD; wa = mem_A;
            end
            if (resp_valid) begin
                rd = resp_rdata; flt = resp_fault;
                break;
            end
        end
        @(negedge clk);
        chk($sformatf("pulse width addr=%h", addr),
            {31'd0, resp_valid}, 32'd0);
    endtask

    int          lat, wec;
    logic [31:0] rd, wd, wa;
    logic        flt;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b10; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;

        tbl.push_back('{1, 2'b10, 0, 32'h70, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF});
        tbl.push_back('{0, 2'b10, 0, 32'h70, 0, 32'hDEADBEEF, 0, 2, 0, 0});
        tbl.push_back('{1, 2'b10, 0, 32'h70, 32'h11223344, 0, 0, 2, 1, 32'h11223344});
        tbl.push_back('{1, 2'b00, 0, 32'h72, 32'h000000AB, 0, 0, 3, 1, 32'h11AB3344});
        tbl.push_back('{0, 2'b10, 0, 32'h70, 0, 32'h11AB3344, 0, 2, 0, 0});
        tbl.push_back('{1, 2'b10, 0, 32'h70, 32'h0000F080, 0, 0, 2, 1, 32'h0000F080});
        tbl.push_back('{0, 2'b01, 1, 32'h70, 0, 32'hFFFFF080, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 32'h70, 0, 32'h0000F080, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b00, 1, 32'h71, 0, 32'hFFFFFFF0, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b00, 0, 32'h70, 0, 32'h00000080, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b00, 1, 32'h70, 0, 32'hFFFFFF80, 0, 2, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 32'h72, 32'h1234BEEF, 0, 0, 3, 1, 32'hBEEFF080});
        tbl.push_back('{0, 2'b01, 0, 32'h72, 0, 32'h0000BEEF, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 32'h1070, 0, 32'hBEEFF080, 0, 2, 0, 0});
`ifdef MEM_ACCESS_ALIGN_FAULT_EN
        tbl.push_back('{1, 2'b10, 0, 32'h72, 32'hCAFEF00D, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 32'h70, 0, 32'hBEEFF080, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b11, 0, 32'h70, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 32'h71, 0, 0, 1, 1, 0, 0});
`else
        tbl.push_back('{1, 2'b10, 0, 32'h72, 32'hCAFEF00D, 0, 0, 2, 1, 32'hCAFEF00D});
        tbl.push_back('{0, 2'b10, 0, 32'h70, 0, 32'hCAFEF00D, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b11, 0, 32'h70, 0, 32'hCAFEF00D, 0, 2, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 32'h71, 0, 32'h0000F00D, 0, 2, 0, 0});
`endif

        #2;
        chk("rst ready", {31'd0, req_ready}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst fault", {31'd0, resp_fault}, 32'd0);
        chk("rst we", {31'd0, mem_WE}, 32'd0);
        chk("rst mem_A", mem_A, 32'd0);
        chk("rst mem_WD", mem_WD, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready after rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            txn(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr,
                tbl[i].wdata, lat, rd, flt, wec, wd, wa);
            chk($sformatf("v%0d rdata", i), rd, tbl[i].rdata);
            chk($sformatf("v%0d fault", i), {31'd0, flt},
                {31'd0, tbl[i].flt});
            chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d we cycles", i), wec, tbl[i].wec);
            if (tbl[i].wec > 0) begin
                chk($sformatf("v%0d mem_WD", i), wd, tbl[i].wd);
                chk($sformatf("v%0d mem_A", i), wa, 32'd28);
            end
        end
        chk("mem28 after table", mem[28], M28_END);

        // back-to-back: preload words 29/30, then hold req_valid high
        txn(1, 2'b10, 0, 32'h74, 32'h29292929, lat, rd, flt, wec, wd, wa);
        txn(1, 2'b10, 0, 32'h78, 32'h30303030, lat, rd, flt, wec, wd, wa);
        begin
            logic [31:0] addrs [3];
            logic [31:0] exps  [3];
            int nacc, nresp, dbl, rdy_err;
            logic prev_rv, prev_acc, acc;
            addrs[0] = 32'h70; addrs[1] = 32'h74; addrs[2] = 32'h78;
            exps[0] = M28_END; exps[1] = 32'h29292929;
            exps[2] = 32'h30303030;
            nacc = 0; nresp = 0; dbl = 0; rdy_err = 0;
            prev_rv = 1'b0; prev_acc = 1'b0;
            @(negedge clk);
            req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
            req_addr = addrs[0]; req_valid = 1'b1;
            for (int c = 0; c < 40 && nresp < 3; c++) begin
                if (c > 0) @(negedge clk);
                if (resp_valid) begin
                    chk($sformatf("b2b rdata %0d", nresp), resp_rdata,
                        exps[nresp]);
                    if (prev_rv) dbl++;
                    nresp++;
                end
                if (prev_acc && req_ready) rdy_err++;
                if (resp_valid && req_ready) rdy_err++;
                prev_rv = resp_valid;
                acc = req_ready && req_valid;
                prev_acc = acc;
                @(posedge clk);
                #1;
                if (acc) begin
                    nacc++;
                    if (nacc < 3) req_addr = addrs[nacc];
                    else req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            chk("b2b accepts", nacc, 3);
            chk("b2b responses", nresp, 3);
            chk("b2b double pulse", dbl, 0);
            chk("b2b ready between", rdy_err, 0);
        end

        // reset during the WRITE cycle of a byte RMW
        begin
            logic [31:0] snap;
            int rv_seen;
            repeat (2) @(negedge clk);
            snap = mem[28];
            rv_seen = 0;
            req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
            req_addr = 32'h70; req_wdata = 32'h55; req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(posedge clk);
            #2;
            chk("rmw we in write", {31'd0, mem_WE}, 32'd1);
            rst = 1'b0;
            #1;
            chk("rst drops we", {31'd0, mem_WE}, 32'd0);
            chk("rst drops ready", {31'd0, req_ready}, 32'd0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (resp_valid || mem_WE) rv_seen++;
            end
            rst = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (resp_valid || mem_WE) rv_seen++;
            end
            chk("no resp/we after rst", rv_seen, 0);
            chk("ready after mid rst", {31'd0, req_ready}, 32'd1);
            chk("mem unchanged by rst", mem[28], snap);
            txn(0, 2'b10, 0, 32'h70, 0, lat, rd, flt, wec, wd, wa);
            chk("load after rst", rd, snap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port.
- Accepts load/store requests from the MEM pipeline stage over a valid/ready handshake.
- Converts byte addresses to word indices for the word-organised data memory, and performs byte and halfword access with sign/zero extension on loads.
- Sub-word stores use read-modify-write.
- Returns a one-cycle response pulse carrying load data and a fault flag.

Parameters:
- DATA_W, 32, data word width; must be 32.
- DEPTH_LOG2, 10, log2 of memory depth in words; the word index is taken from addr[DEPTH_LOG2+1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  request was rejected with no memory access.
- mem_A  out  32  word index to memory, computed as zero-extended addr[DEPTH_LOG2+1:2].
- mem_WD  out  32  write data to memory.
- mem_WE  out  1  write enable; memory writes on the clk edge.
- mem_RD  in  32  combinational read data for mem_A.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0 while reset is asserted, 1 after release.
  - resp_valid=0, resp_rdata=0, resp_fault=0, mem_WE=0, mem_A=0, mem_WD=0.
  - Any in-flight request is dropped: no write, no response.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch we/size/signed/addr/wdata.
  - If the request is misaligned, go to RESP with fault pending. Misaligned means a half access with addr[0]=1, a word access with addr[1:0]!=0, or size=11.
  - Otherwise go to ACCESS.
- req_ready=0 in every state except IDLE. A new request can be accepted one cycle after resp_valid, earliest.
- ACCESS (mem_A = word index of the latched address):
  - Load: select the lane, then zero- or sign-extend.
    - Byte lane = addr[1:0]*8.
    - Half lane = addr[1]*16.
    - Little-endian.
    - Register the result; go to RESP.
  - Word store: mem_WE=1, mem_WD=wdata; go to RESP.
  - Byte/half store: register mem_RD as the old word; go to WRITE. mem_WE stays 0.
- WRITE:
  - mem_WE=1.
  - mem_WD = old word with the target lane replaced by wdata[7:0] or wdata[15:0]; all other lanes unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata is valid data for loads and 0 otherwise; resp_fault is set as latched.
  - Go to IDLE. resp_* return to 0 the next cycle.
- Latency from the accept edge to the resp_valid cycle:
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- mem_WE is asserted only in ACCESS (word store) or WRITE, and never for longer than 1 cycle per request.
- mem_A holds its value from ACCESS through WRITE.
- Address bits above DEPTH_LOG2+1 are ignored; the index wraps modulo memory depth.
- A fault never asserts mem_WE.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_FAULT_EN.
- Defined: misaligned or reserved-size requests fault as described above.
- Undefined:
  - resp_fault is tied to 0.
  - Misaligned half/word addresses are aligned down (low address bits cleared).
  - size=11 is treated as a word access.
  - All requests perform the access.

Decomposition:
- Shared package mem_access_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - The state enum.
  - The DATA_W constant.
- Sub-module mem_lane_align: combinational lane extract/extend for loads and lane merge for stores. It is shared by both paths and unit-tested separately.

Test Plan:
1. Word store then load. Store addr=0x70, data=0xDEADBEEF, size=10: mem_A=28 and mem_WE=1 for 1 cycle, resp 2 cycles after accept. Then load addr=0x70: resp_rdata=0xDEADBEEF, fault=0.
2. Byte store RMW. Word 28 = 0x11223344; store byte addr=0x72, wdata=0xAB: one read cycle, then mem_WD=0x11AB3344, WE for exactly 1 cycle, resp 3 cycles after accept.
3. Sign/zero extension. Word 28 = 0x0000F080; load half addr=0x70 signed=1 → 0xFFFFF080; signed=0 → 0x0000F080; load byte addr=0x71 signed=1 → 0xFFFFFFF0.
4. Misaligned (feature on). Store word addr=0x72: resp_fault=1 one cycle after accept, mem_WE never asserted, memory unchanged. With the feature off, the same request writes word 28.
5. Back-to-back handshake. req_valid held high for 3 requests: req_ready is low between accepts, each response is a single-cycle pulse, and no request is lost or duplicated.
6. Reset mid-RMW. rst=0 asynchronously during WRITE: mem_WE drops immediately, no resp_valid, memory unchanged. After release, req_ready=1 in IDLE.
